fifo_bit_packer: RTL and testbench

Read-side companion to the 1-bit `fifo_stack_u` buffer in the USB3300 parser path. It drains the FIFO one bit at a time with the `pop`/`busy`/`empty` protocol and assembles WIDTH bits into a parallel word. It presents that word to a downstream consumer, such as the UART transmitter, over a valid/ready handshake. It is the counterpart of the bit writer that feeds the FIFO through `save`.

---
 rtl/fifo_bit_packer.sv | 154 +++++++++++++++
 tb/tb_fifo_bit_packer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_bit_packer.sv
// Drains a 1-bit FIFO through the pop/busy/empty protocol and packs WIDTH bits into a word offered on valid/ready.
// Optional partial-word flush (flush input, O_LEN output) is enabled by defining FIFO_PACKER_FLUSH_EN.
module fifo_bit_packer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         I_DATA,
    input  logic                         empty,
    input  logic                         busy,
    output logic                         pop,
    output logic [WIDTH-1:0]             O_DATA,
    input  logic                         ready,
`ifdef FIFO_PACKER_FLUSH_EN
    input  logic                         flush,
    output logic [$clog2(WIDTH+1)-1:0]   O_LEN,
`endif
    output logic                         valid
);

    localparam int unsigned      CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] idx_c;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nx;
    logic [WIDTH-1:0] word_c;
    logic [WIDTH-1:0] data_nx;
    logic             pop_nx;
    logic             valid_nx;

`ifdef FIFO_PACKER_FLUSH_EN
    localparam int unsigned LEN_W = $clog2(WIDTH + 1);

    logic [LEN_W-1:0] len_nx;
    logic [WIDTH-1:0] fmask_c;

    // Positions already written for the current partial word.
    always_comb begin
        fmask_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) begin
                fmask_c[i] = ((i + 32'(cnt)) >= WIDTH);
            end else begin
                fmask_c[i] = (i < 32'(cnt));
            end
        end
    end
`endif

    // Shift register with the incoming bit merged at its slot.
    always_comb begin
        idx_c = MSB_FIRST ? (CNT_MAX - cnt) : cnt;
        word_c        = sr;
        word_c[idx_c] = I_DATA;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sr_nx    = sr;
        data_nx  = O_DATA;
        valid_nx = valid;
        pop_nx   = 1'b0;
`ifdef FIFO_PACKER_FLUSH_EN
        len_nx   = O_LEN;
`endif
        case (state)
            S_IDLE: begin
`ifdef FIFO_PACKER_FLUSH_EN
                if (flush && (cnt != '0)) begin
                    data_nx  = sr & fmask_c;
                    len_nx   = LEN_W'(cnt);
                    valid_nx = 1'b1;
                    cnt_nx   = '0;
                    state_nx = S_HOLD;
                end else
`endif
                if (!empty && !busy) begin
                    pop_nx   = 1'b1;
                    state_nx = S_POP;
                end
            end
            S_POP: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (!busy) begin
                    sr_nx = word_c;
                    if (cnt == CNT_MAX) begin
                        data_nx  = word_c;
                        valid_nx = 1'b1;
                        cnt_nx   = '0;
                        state_nx = S_HOLD;
`ifdef FIFO_PACKER_FLUSH_EN
                        len_nx   = LEN_W'(WIDTH);
`endif
                    end else begin
                        cnt_nx   = cnt + CNT_W'(1);
                        state_nx = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (ready) begin
                    valid_nx = 1'b0;
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; pop is high exactly while in S_POP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            sr     <= '0;
            O_DATA <= '0;
            valid  <= 1'b0;
            pop    <= 1'b0;
`ifdef FIFO_PACKER_FLUSH_EN
            O_LEN  <= '0;
`endif
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            sr     <= sr_nx;
            O_DATA <= data_nx;
            valid  <= valid_nx;
            pop    <= pop_nx;
`ifdef FIFO_PACKER_FLUSH_EN
            O_LEN  <= len_nx;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_bit_packer.sv
// Directed bench: two packers (LSB-first lane 0, MSB-first lane 1), each fed by its own 1-bit FIFO model with busy length 2.
module tb_fifo_bit_packer;

    localparam int BUSY_LEN = 2;
    localparam int LEN_W    = $clog2(9);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ready = 1'b0;
    logic flush = 1'b0;

    logic             pop_l   [2];
    logic             valid_l [2];
    logic [7:0]       odata_l [2];
    logic [LEN_W-1:0] olen_l  [2];
    logic             empty_l [2];
    logic             busy_l  [2];
    bit               idata_l [2];

    bit fbits [2][256];
    int head  [2] = '{default: 0};
    int tail  [2] = '{default: 0};
    int bcnt  [2] = '{default: 0};
    int npops [2] = '{default: 0};
    int viol  [2] = '{default: 0};
    bit prev_pop [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        fifo_bit_packer #(
            .WIDTH     (8),
            .MSB_FIRST (g == 1)
        ) dut (
            .clk    (clk),
            .reset  (reset),
            .I_DATA (idata_l[g]),
            .empty  (empty_l[g]),
            .busy   (busy_l[g]),
            .pop    (pop_l[g]),
            .O_DATA (odata_l[g]),
            .ready  (ready),
`ifdef FIFO_PACKER_FLUSH_EN
            .flush  (flush),
            .O_LEN  (olen_l[g]),
`endif
            .valid  (valid_l[g])
        );
    end

`ifndef FIFO_PACKER_FLUSH_EN
    always_comb begin
        for (int g = 0; g < 2; g++) olen_l[g] = '0;
    end
`endif

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            empty_l[g] = (head[g] == tail[g]);
            busy_l[g]  = (bcnt[g] != 0);
        end
    end

    // FIFO model plus pop protocol monitor.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (pop_l[g] === 1'b1) begin
                npops[g] <= npops[g] + 1;
                if (empty_l[g] || busy_l[g] || prev_pop[g]) viol[g] <= viol[g] + 1;
            end
            prev_pop[g] <= (pop_l[g] === 1'b1);
            if (bcnt[g] != 0) begin
                bcnt[g] <= bcnt[g] - 1;
            end else if (pop_l[g] === 1'b1 && !empty_l[g]) begin
                bcnt[g]    <= BUSY_LEN;
                idata_l[g] <= fbits[g][head[g]];
                head[g]    <= head[g] + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bit(input bit b);
        for (int g = 0; g < 2; g++) begin
            fbits[g][tail[g]] = b;
            tail[g] = tail[g] + 1;
        end
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) push_bit(v[i]);
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = (valid_l[0] === 1'b1) && (valid_l[1] === 1'b1);
        end
    endtask

    task automatic wait_drained(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = empty_l[0] && empty_l[1] && !busy_l[0] && !busy_l[1];
        end
        tick();
        tick();
    endtask

    task automatic release_word();
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ready = 1'b0;
        flush = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (pop_l[g] !== 1'b0) begin errors++; $display("FAIL reset_pop lane%0d: got %b want 0", g, pop_l[g]); end
            checks++;
            if (valid_l[g] !== 1'b0) begin errors++; $display("FAIL reset_valid lane%0d: got %b want 0", g, valid_l[g]); end
            checks++;
            if (odata_l[g] !== 8'h00) begin errors++; $display("FAIL reset_data lane%0d: got %h want 00", g, odata_l[g]); end
`ifdef FIFO_PACKER_FLUSH_EN
            checks++;
            if (olen_l[g] !== 4'd0) begin errors++; $display("FAIL reset_len lane%0d: got %0d want 0", g, olen_l[g]); end
`endif
        end
        repeat (20) tick();
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (npops[g] !== 0) begin errors++; $display("FAIL idle_pops lane%0d: got %0d want 0", g, npops[g]); end
            checks++;
            if (valid_l[g] !== 1'b0) begin errors++; $display("FAIL idle_valid lane%0d: got %b want 0", g, valid_l[g]); end
            checks++;
            if (odata_l[g] !== 8'h00) begin errors++; $display("FAIL idle_data lane%0d: got %h want 00", g, odata_l[g]); end
        end
    endtask

    task automatic test_word();
        logic [7:0] exp_d [2];
        bit ok;
        exp_d[0] = 8'h4D;
        exp_d[1] = 8'hB2;
        push_byte(8'h4D);
        wait_valid(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL word_timeout: valid %b/%b want 1/1", valid_l[0], valid_l[1]); end
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (odata_l[g] !== exp_d[g]) begin errors++; $display("FAIL word_data lane%0d: got %h want %h", g, odata_l[g], exp_d[g]); end
            checks++;
            if (npops[g] !== 8) begin errors++; $display("FAIL word_pops lane%0d: got %0d want 8", g, npops[g]); end
            checks++;
            if (viol[g] !== 0) begin errors++; $display("FAIL word_protocol lane%0d: got %0d violations want 0", g, viol[g]); end
`ifdef FIFO_PACKER_FLUSH_EN
            checks++;
            if (olen_l[g] !== 4'd8) begin errors++; $display("FAIL word_len lane%0d: got %0d want 8", g, olen_l[g]); end
`endif
        end
    endtask

    task automatic test_hold();
        logic [7:0] held [2];
        logic [7:0] exp_d [2];
        int base [2];
        bit changed;
        bit ok;
        held[0]  = 8'h4D;
        held[1]  = 8'hB2;
        exp_d[0] = 8'h1E;
        exp_d[1] = 8'h78;
        base[0]  = npops[0];
        base[1]  = npops[1];
        changed  = 1'b0;
        push_byte(8'h1E);
        repeat (10) begin
            tick();
            if (odata_l[0] !== held[0] || odata_l[1] !== held[1]) changed = 1'b1;
        end
        checks++;
        if (changed) begin errors++; $display("FAIL hold_stable: data moved to %h/%h want %h/%h", odata_l[0], odata_l[1], held[0], held[1]); end
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (npops[g] !== base[g]) begin errors++; $display("FAIL hold_no_pop lane%0d: got %0d pops want %0d", g, npops[g], base[g]); end
            checks++;
            if (valid_l[g] !== 1'b1) begin errors++; $display("FAIL hold_valid lane%0d: got %b want 1", g, valid_l[g]); end
        end
        release_word();
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (valid_l[g] !== 1'b0) begin errors++; $display("FAIL release_valid lane%0d: got %b want 0", g, valid_l[g]); end
            checks++;
            if (pop_l[g] !== 1'b0) begin errors++; $display("FAIL release_early_pop lane%0d: got %b want 0", g, pop_l[g]); end
        end
        tick();
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (pop_l[g] !== 1'b1) begin errors++; $display("FAIL release_next_pop lane%0d: got %b want 1", g, pop_l[g]); end
        end
        wait_valid(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hold_word2_timeout: valid %b/%b want 1/1", valid_l[0], valid_l[1]); end
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (odata_l[g] !== exp_d[g]) begin errors++; $display("FAIL hold_word2_data lane%0d: got %h want %h", g, odata_l[g], exp_d[g]); end
        end
        release_word();
    endtask

    task automatic test_reset_mid();
        int base [2];
        bit ok;
        push_bit(1'b1);
        push_bit(1'b1);
        push_bit(1'b1);
        wait_drained(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midreset_drain: empty %b busy %b want 1/0", empty_l[0], busy_l[0]); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (odata_l[g] !== 8'h00) begin errors++; $display("FAIL midreset_data lane%0d: got %h want 00", g, odata_l[g]); end
        end
        base[0] = npops[0];
        base[1] = npops[1];
        push_byte(8'hA5);
        wait_valid(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midreset_timeout: valid %b/%b want 1/1", valid_l[0], valid_l[1]); end
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (odata_l[g] !== 8'hA5) begin errors++; $display("FAIL midreset_word lane%0d: got %h want a5", g, odata_l[g]); end
            checks++;
            if (npops[g] - base[g] !== 8) begin errors++; $display("FAIL midreset_pops lane%0d: got %0d want 8", g, npops[g] - base[g]); end
`ifdef FIFO_PACKER_FLUSH_EN
            checks++;
            if (olen_l[g] !== 4'd8) begin errors++; $display("FAIL midreset_len lane%0d: got %0d want 8", g, olen_l[g]); end
`endif
        end
        release_word();
    endtask

`ifdef FIFO_PACKER_FLUSH_EN
    task automatic test_flush();
        logic [7:0] exp_d [2];
        int base [2];
        bit ok;
        exp_d[0] = 8'h03;
        exp_d[1] = 8'hC0;
        push_bit(1'b1);
        push_bit(1'b1);
        push_bit(1'b0);
        wait_drained(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL flush_drain: empty %b busy %b want 1/0", empty_l[0], busy_l[0]); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (valid_l[g] !== 1'b1) begin errors++; $display("FAIL flush_valid lane%0d: got %b want 1", g, valid_l[g]); end
            checks++;
            if (odata_l[g] !== exp_d[g]) begin errors++; $display("FAIL flush_data lane%0d: got %h want %h", g, odata_l[g], exp_d[g]); end
            checks++;
            if (olen_l[g] !== 4'd3) begin errors++; $display("FAIL flush_len lane%0d: got %0d want 3", g, olen_l[g]); end
        end
        release_word();
        base[0] = npops[0];
        base[1] = npops[1];
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (valid_l[g] !== 1'b0) begin errors++; $display("FAIL flush_empty_valid lane%0d: got %b want 0", g, valid_l[g]); end
            checks++;
            if (npops[g] !== base[g]) begin errors++; $display("FAIL flush_empty_pops lane%0d: got %0d want %0d", g, npops[g], base[g]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_word();
        test_hold();
        test_reset_mid();
`ifdef FIFO_PACKER_FLUSH_EN
        test_flush();
`endif
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (viol[g] !== 0) begin errors++; $display("FAIL pop_protocol lane%0d: got %0d violations want 0", g, viol[g]); end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
